// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier.
// Accepts one signed operand pair, retires one Booth digit per cycle and
// returns the exact signed 2W-bit product through a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | consuming Booth digit k each edge; busy high, sdn live
// DONE  | product valid; holds until out_ready or abort
module booth_mult_seq #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    multiplicand,
    input  logic [W-1:0]    multiplier,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  product,
    output logic            busy,
    output logic [2:0]      sdn
);

    localparam int N  = W / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [W-1:0]       m_reg;
    logic [W-1:0]       q_reg;
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     acc_next;
    logic [KW-1:0]      k;
    logic [W:0]         q_ext;
    logic [2:0]         triple;
    logic [2:0]         sel;
    logic [2*W-1:0]     m_ext;
    logic [2*W-1:0]     pp;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort takes priority over completion and handoff
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = RUN;
            RUN: begin
                if (abort)            state_next = IDLE;
                else if (k == K_LAST) state_next = DONE;
            end
            DONE: if (abort || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state; sdn only shows a digit while running
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
        sdn       = (state == RUN) ? sel : 3'b000;
    end

    // Booth recoding of the current digit; q_ext carries the implicit Q[-1]=0
    always_comb begin
        q_ext  = {q_reg, 1'b0};
        triple = q_ext[{k, 1'b0} +: 3];
        unique case (triple)
            3'b001, 3'b010: sel = 3'b010;
            3'b011:         sel = 3'b100;
            3'b100:         sel = 3'b101;
            3'b101, 3'b110: sel = 3'b011;
            default:        sel = 3'b000;
        endcase
    end

    // Partial product digit*M, sign-extended and aligned to digit position 2k
    always_comb begin
        m_ext = {{W{m_reg[W-1]}}, m_reg};
        unique case (sel)
            3'b010:  pp = m_ext;
            3'b100:  pp = m_ext << 1;
            3'b011:  pp = -m_ext;
            3'b101:  pp = -(m_ext << 1);
            default: pp = '0;
        endcase
        acc_next = acc + (pp << {k, 1'b0});
    end

    // Operand capture, accumulation and product register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_reg   <= '0;
            q_reg   <= '0;
            acc     <= '0;
            k       <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        acc   <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    if (!abort) begin
                        acc <= acc_next;
                        k   <= k + 1'b1;
                        if (k == K_LAST) product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks for booth_mult_seq (W=8).
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    logic [2:0]  sdn;

    int n_tests = 0;
    int n_fail  = 0;

    booth_mult_seq #(.W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy),
        .sdn          (sdn)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one pair, wait for the result, check latency/product, hand it off.
    task automatic do_op(input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp, input string tag);
        int lat;
        in_valid     = 1'b1;
        multiplicand = m;
        multiplier   = q;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid     = 1'b0;
        multiplicand = 8'($urandom);
        multiplier   = 8'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_product"}, {16'd0, product}, {16'd0, exp});
        chk({tag, "_sdn_done"}, {29'd0, sdn}, 32'd0);
        chk({tag, "_excl"}, {31'd0, in_ready & out_valid}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        abort        = 1'b0;
        out_ready    = 1'b0;
        multiplicand = 8'd0;
        multiplier   = 8'd0;
        tick();
        tick();
        chk("reset_flags", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
        chk("reset_sdn", {29'd0, sdn}, 32'd0);
        chk("reset_product", {16'd0, product}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 7*3, digits of Q=3 are -1,+1,0,0
        in_valid = 1'b1; multiplicand = 8'd7; multiplier = 8'd3;
        tick();
        in_valid = 1'b0; multiplicand = 8'hAA; multiplier = 8'h55;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_sdn0", {29'd0, sdn}, 32'b011);
        tick();
        chk("t1_sdn1", {29'd0, sdn}, 32'b010);
        tick();
        chk("t1_sdn2", {29'd0, sdn}, 32'b000);
        tick();
        chk("t1_sdn3", {29'd0, sdn}, 32'b000);
        chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_product", {16'd0, product}, 32'd21);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 2: extremes
        do_op(8'h80, 8'h80, 16'h4000, "t2a");
        do_op(8'h7F, 8'h80, 16'hC080, "t2b");

        // 3: stall in DONE
        in_valid = 1'b1; multiplicand = 8'hF8; multiplier = 8'h08;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {14'd0, product, out_valid, in_ready}, {14'd0, 16'hFFC0, 2'b10});
            tick();
        end
        chk("t3_still", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_idle", {30'd0, in_ready, out_valid}, 32'b10);

        // 4: back-to-back with out_ready and in_valid held high
        out_ready = 1'b1;
        in_valid = 1'b1; multiplicand = 8'd5; multiplier = 8'hFF;
        tick();
        multiplicand = 8'hFD; multiplier = 8'hFD;
        repeat (4) tick();
        chk("t4_first", {15'd0, out_valid, product}, {15'd0, 1'b1, 16'hFFFB});
        tick();
        chk("t4_idle_between", {30'd0, in_ready, out_valid}, 32'b10);
        tick();
        in_valid = 1'b0;
        chk("t4_second_busy", {31'd0, busy}, 32'd1);
        repeat (3) tick();
        chk("t4_second_wait", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t4_second", {15'd0, out_valid, product}, {15'd0, 1'b1, 16'd9});
        tick();
        out_ready = 1'b0;

        // 5: reset on the second RUN edge
        in_valid = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_reset_flags", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
        chk("t5_reset_out", {13'd0, sdn, product}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t5_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        do_op(8'd2, 8'd2, 16'd4, "t5_after");

        // 6a: abort on the final RUN edge
        in_valid = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t6_last_run", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_aborted", {29'd0, in_ready, out_valid, busy}, 32'b100);
        chk("t6_product_kept", {16'd0, product}, 32'd4);
        repeat (3) tick();
        chk("t6_no_valid", {31'd0, out_valid}, 32'd0);

        // 6b: abort in IDLE is ignored, operands accepted
        abort = 1'b1; in_valid = 1'b1; multiplicand = 8'd6; multiplier = 8'd7;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("t6_accepted", {31'd0, busy}, 32'd1);
        repeat (4) tick();
        chk("t6_result", {15'd0, out_valid, product}, {15'd0, 1'b1, 16'd42});

        // 6c: abort together with out_ready in DONE
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        chk("t6_abort_done", {30'd0, in_ready, out_valid}, 32'b10);

        // Random pairs against a signed multiply model
        for (int i = 0; i < 10000; i++) begin
            logic [7:0]  rm;
            logic [7:0]  rq;
            logic [15:0] re;
            rm = 8'($urandom);
            rq = 8'($urandom);
            re = 16'($signed(rm) * $signed(rq));
            do_op(rm, rq, re, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
